mem_arbiter: RTL and testbench

- Shares one single-port unified memory between the instruction-fetch requester (I) and the load/store requester (D) of the multi-cycle core.
- Sits between the program-counter/fetch logic plus the data-access path, and the memory macro.
- Each requester uses a req/gnt/valid handshake.
- D has priority, with a starvation guard that bounds how many consecutive D grants can pass over a pending I request.

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/mem_arbiter_arb_pick.sv | 64 ++++++
 rtl/mem_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package mem_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Which requester owns the memory for the current access.
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int MEM_LAT_DEF    = 1;
  localparam int STARVE_MAX_DEF = 4;

  // Bits needed to hold a counter value in 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Owner selection for the memory arbiter: D wins by default, but once
// STARVE_MAX consecutive D grants have passed over a waiting fetch, I wins.
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_req,
  input  logic   d_req,
  input  logic   grant,
  output owner_t pick,
  output logic   pick_valid
);

  localparam int             SW   = cnt_width(STARVE_MAX);
  localparam logic [SW-1:0]  SMAX = SW'(STARVE_MAX);

  logic [SW-1:0] starve_cnt_q;
  logic [SW-1:0] starve_cnt_d;
  logic          starved_s;

  // Combinational owner choice from the live requests and starvation state.
  always_comb begin
    pick_valid = i_req | d_req;
    starved_s  = (starve_cnt_q == SMAX);
    if (i_req && d_req) begin
      pick = starved_s ? OWN_I : OWN_D;
    end else if (i_req) begin
      pick = OWN_I;
    end else begin
      pick = OWN_D;
    end
  end

  // Count D grants that bypass a waiting fetch; any other grant clears.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant) begin
      if ((pick == OWN_D) && i_req) begin
        if (starved_s) begin
          starve_cnt_d = starve_cnt_q;
        end else begin
          starve_cnt_d = starve_cnt_q + SW'(1);
        end
      end else begin
        starve_cnt_d = {SW{1'b0}};
      end
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= {SW{1'b0}};
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (I) and
// load/store (D). Each access: ISSUE drives the memory for one cycle, WAIT
// spans the read latency and captures the word on its last cycle, RESP
// presents valid and re-arbitrates, so back-to-back accesses are spaced
// MEM_LAT+2 cycles apart. All outputs come straight from flops.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iReq,
  input  logic [ADDR_W-1:0]   iAddr,
  output logic                iGnt,
  output logic                iValid,
  output logic [DATA_W-1:0]   iRdata,
  input  logic                dReq,
  input  logic                dWe,
  input  logic [ADDR_W-1:0]   dAddr,
  input  logic [DATA_W/8-1:0] dBe,
  input  logic [DATA_W-1:0]   dWdata,
  output logic                dGnt,
  output logic                dValid,
  output logic [DATA_W-1:0]   dRdata,
  output logic                memEn,
  output logic [DATA_W/8-1:0] memWe,
  output logic [ADDR_W-1:0]   memAddr,
  output logic [DATA_W-1:0]   memWdata,
  input  logic [DATA_W-1:0]   memRdata,
  output logic                busy
);

  localparam int                BE_W       = DATA_W / 8;
  localparam int                CW         = cnt_width(MEM_LAT - 1);
  localparam logic [CW-1:0]     CNT_INIT   = CW'(MEM_LAT - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_t              state_q,     state_d;
  owner_t              owner_q,     owner_d;
  logic                store_q,     store_d;
  logic [CW-1:0]       lat_cnt_q,   lat_cnt_d;
  logic                i_gnt_q,     i_gnt_d;
  logic                d_gnt_q,     d_gnt_d;
  logic                i_valid_q,   i_valid_d;
  logic                d_valid_q,   d_valid_d;
  logic [DATA_W-1:0]   i_rdata_q,   i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;
  logic                mem_en_q,    mem_en_d;
  logic [BE_W-1:0]     mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                busy_q,      busy_d;

  owner_t              pick_s;
  logic                pick_valid_s;
  logic                arb_s;

  // A grant is made whenever an arbitration state sees a pending request.
  assign arb_s = ((state_q == S_IDLE) || (state_q == S_RESP)) && pick_valid_s;

  arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb_pick (
    .clk        (clk),
    .rst        (rst),
    .i_req      (iReq),
    .d_req      (dReq),
    .grant      (arb_s),
    .pick       (pick_s),
    .pick_valid (pick_valid_s)
  );

  // Next-state and next-output logic for the access sequence.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    store_d     = store_q;
    lat_cnt_d   = lat_cnt_q;
    i_gnt_d     = 1'b0;
    d_gnt_d     = 1'b0;
    i_valid_d   = 1'b0;
    d_valid_d   = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = {BE_W{1'b0}};
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = 1'b1;

    case (state_q)
      S_IDLE, S_RESP: begin
        if (arb_s) begin
          state_d  = S_ISSUE;
          owner_d  = pick_s;
          mem_en_d = 1'b1;
          if (pick_s == OWN_D) begin
            d_gnt_d    = 1'b1;
            store_d    = dWe;
            mem_addr_d = dAddr & ALIGN_MASK;
            if (dWe) begin
              mem_we_d    = dBe;
              mem_wdata_d = dWdata;
            end else begin
              mem_we_d    = {BE_W{1'b0}};
              mem_wdata_d = mem_wdata_q;
            end
          end else begin
            i_gnt_d    = 1'b1;
            store_d    = 1'b0;
            mem_addr_d = iAddr & ALIGN_MASK;
          end
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end

      S_ISSUE: begin
        state_d   = S_WAIT;
        lat_cnt_d = CNT_INIT;
      end

      S_WAIT: begin
        if (lat_cnt_q == {CW{1'b0}}) begin
          state_d = S_RESP;
          if (owner_q == OWN_D) begin
            d_valid_d = 1'b1;
            if (store_q) begin
              d_rdata_d = d_rdata_q;
            end else begin
              d_rdata_d = memRdata;
            end
          end else begin
            i_valid_d = 1'b1;
            i_rdata_d = memRdata;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - CW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counters and every output register; reset abandons any access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_I;
      store_q     <= 1'b0;
      lat_cnt_q   <= {CW{1'b0}};
      i_gnt_q     <= 1'b0;
      d_gnt_q     <= 1'b0;
      i_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      i_rdata_q   <= {DATA_W{1'b0}};
      d_rdata_q   <= {DATA_W{1'b0}};
      mem_en_q    <= 1'b0;
      mem_we_q    <= {BE_W{1'b0}};
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      store_q     <= store_d;
      lat_cnt_q   <= lat_cnt_d;
      i_gnt_q     <= i_gnt_d;
      d_gnt_q     <= d_gnt_d;
      i_valid_q   <= i_valid_d;
      d_valid_q   <= d_valid_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign iGnt     = i_gnt_q;
  assign dGnt     = d_gnt_q;
  assign iValid   = i_valid_q;
  assign dValid   = d_valid_q;
  assign iRdata   = i_rdata_q;
  assign dRdata   = d_rdata_q;
  assign memEn    = mem_en_q;
  assign memWe    = mem_we_q;
  assign memAddr  = mem_addr_q;
  assign memWdata = mem_wdata_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: instance 0 uses MEM_LAT=1, instance 1
// uses MEM_LAT=3. Stimulus pushes expected grants/responses; a monitor pops
// and compares whenever a DUT raises a gnt or valid.
module tb_mem_arbiter;

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst      [2];
  logic        iReq     [2];
  logic [31:0] iAddr    [2];
  logic        iGnt     [2];
  logic        iValid   [2];
  logic [31:0] iRdata   [2];
  logic        dReq     [2];
  logic        dWe      [2];
  logic [31:0] dAddr    [2];
  logic [3:0]  dBe      [2];
  logic [31:0] dWdata   [2];
  logic        dGnt     [2];
  logic        dValid   [2];
  logic [31:0] dRdata   [2];
  logic        memEn    [2];
  logic [3:0]  memWe    [2];
  logic [31:0] memAddr  [2];
  logic [31:0] memWdata [2];
  logic [31:0] memRdata [2];
  logic        busy     [2];

  exp_t gq [2][$];
  exp_t rq [2][$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents seen by reads.
  function automatic logic [31:0] mword(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'h0010_0093;
      32'h0000_0020: return 32'h1234_5678;
      default:       return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int ML = (g == 0) ? 1 : 3;
    logic [31:0] pd [ML];
    logic        pv [ML];

    // Read word appears exactly ML cycles after the memEn cycle, junk otherwise.
    always @(posedge clk) begin
      pv[0] <= memEn[g] && (memWe[g] == 4'h0);
      pd[0] <= mword(memAddr[g]);
      for (int i = 1; i < ML; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
    assign memRdata[g] = pv[ML-1] ? pd[ML-1] : 32'hBAD0_BAD0;

    mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LAT(ML), .STARVE_MAX(4)
    ) u_dut (
      .clk(clk), .rst(rst[g]),
      .iReq(iReq[g]), .iAddr(iAddr[g]), .iGnt(iGnt[g]), .iValid(iValid[g]), .iRdata(iRdata[g]),
      .dReq(dReq[g]), .dWe(dWe[g]), .dAddr(dAddr[g]), .dBe(dBe[g]), .dWdata(dWdata[g]),
      .dGnt(dGnt[g]), .dValid(dValid[g]), .dRdata(dRdata[g]),
      .memEn(memEn[g]), .memWe(memWe[g]), .memAddr(memAddr[g]), .memWdata(memWdata[g]),
      .memRdata(memRdata[g]), .busy(busy[g])
    );
  end

  task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (dut%0d) cyc=%0d: got %h want %h", nm, k, cyc, act, exp);
    end
  endtask

  // Monitor: compare every grant and every valid against the scoreboard.
  exp_t me;
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      if (!rst[k]) begin
        chk(k, "memen_vs_gnt", {31'd0, memEn[k]}, {31'd0, iGnt[k] | dGnt[k]});
        if (iGnt[k] || dGnt[k]) begin
          chk(k, "gnt_excl", {31'd0, iGnt[k] & dGnt[k]}, 32'd0);
          chk(k, "gnt_expected", {31'd0, gq[k].size() != 0}, 32'd1);
          if (gq[k].size() != 0) begin
            me = gq[k].pop_front();
            chk(k, "gnt_owner", {31'd0, dGnt[k]}, {31'd0, me.is_d});
            chk(k, "gnt_cycle", 32'(cyc), 32'(me.cyc));
            chk(k, "mem_addr", memAddr[k], me.addr);
            chk(k, "mem_we", {28'd0, memWe[k]}, {28'd0, me.we});
            if (me.we != 4'h0) chk(k, "mem_wdata", memWdata[k], me.wdata);
          end
        end
        if (iValid[k] || dValid[k]) begin
          chk(k, "valid_excl", {31'd0, iValid[k] & dValid[k]}, 32'd0);
          chk(k, "valid_expected", {31'd0, rq[k].size() != 0}, 32'd1);
          if (rq[k].size() != 0) begin
            me = rq[k].pop_front();
            chk(k, "valid_owner", {31'd0, dValid[k]}, {31'd0, me.is_d});
            chk(k, "valid_cycle", 32'(cyc), 32'(me.cyc));
            chk(k, "rdata", me.is_d ? dRdata[k] : iRdata[k], me.rdata);
          end
        end
      end
    end
  end

  // Raise one request at the current negedge (DUT idle), hold until granted.
  task automatic issue(input int k, input logic is_d, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wdata,
                       input logic [31:0] exp_addr, input logic [31:0] exp_rd);
    exp_t e;
    int   lat;
    bit   got;
    lat     = (k == 0) ? 1 : 3;
    e.is_d  = is_d;
    e.addr  = exp_addr;
    e.we    = (is_d && we) ? be : 4'h0;
    e.wdata = wdata;
    e.rdata = exp_rd;
    e.cyc   = cyc + 1;
    gq[k].push_back(e);
    e.cyc   = cyc + 2 + lat;
    rq[k].push_back(e);
    if (is_d) begin
      dReq[k] = 1'b1; dWe[k] = we; dAddr[k] = addr; dBe[k] = be; dWdata[k] = wdata;
    end else begin
      iReq[k] = 1'b1; iAddr[k] = addr;
    end
    got = 1'b0;
    for (int n = 0; n < 8 && !got; n++) begin
      @(negedge clk);
      if (is_d ? dGnt[k] : iGnt[k]) got = 1'b1;
    end
    chk(k, "gnt_seen", {31'd0, got}, 32'd1);
    dReq[k] = 1'b0;
    iReq[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 30 && !idle; n++) begin
      @(negedge clk);
      if (!busy[k]) idle = 1'b1;
    end
    chk(k, "idle_reached", {31'd0, idle}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        e;
    int          c;
    int          n;
    logic [9:0]  pat;

    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; iReq[k] = 1'b0; iAddr[k] = 32'h0; dReq[k] = 1'b0; dWe[k] = 1'b0;
      dAddr[k] = 32'h0; dBe[k] = 4'h0; dWdata[k] = 32'h0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk(k, "rst_busy", {31'd0, busy[k]}, 32'd0);
      chk(k, "rst_memen", {31'd0, memEn[k]}, 32'd0);
      chk(k, "rst_irdata", iRdata[k], 32'h0);
      chk(k, "rst_drdata", dRdata[k], 32'h0);
      chk(k, "rst_memaddr", memAddr[k], 32'h0);
      rst[k] = 1'b0;
    end
    @(negedge clk);

    // Single fetch, MEM_LAT=1: gnt c+1, valid c+3, idle c+4.
    issue(0, 1'b0, 1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'h0000_0010, 32'h0010_0093);
    repeat (3) @(negedge clk);
    chk(0, "t1_busy_after", {31'd0, busy[0]}, 32'd0);

    // Store with partial byte enables on an unaligned address.
    issue(0, 1'b1, 1'b1, 32'h0000_0103, 4'b0011, 32'hDEAD_BEEF, 32'h0000_0100, 32'h0);
    wait_idle(0);
    chk(0, "t2_drdata_kept", dRdata[0], 32'h0);

    // Both requesters held: D,D,D,D,I,D,D,D,D,I every 3 cycles.
    pat = 10'b0111101111;
    c = cyc;
    for (int j = 0; j < 10; j++) begin
      e.is_d  = pat[j];
      e.addr  = pat[j] ? 32'h0000_0044 : 32'h0000_0040;
      e.we    = 4'h0;
      e.wdata = 32'h0;
      e.rdata = pat[j] ? 32'hC0DE_0044 : 32'hC0DE_0040;
      e.cyc   = c + 1 + 3 * j;
      gq[0].push_back(e);
      e.cyc   = c + 3 + 3 * j;
      rq[0].push_back(e);
    end
    iReq[0] = 1'b1; iAddr[0] = 32'h0000_0040;
    dReq[0] = 1'b1; dWe[0] = 1'b0; dAddr[0] = 32'h0000_0044;
    n = 0;
    for (int w = 0; w < 60 && n < 10; w++) begin
      @(negedge clk);
      if (iGnt[0] || dGnt[0]) n++;
    end
    chk(0, "t3_gnt_count", 32'(n), 32'd10);
    iReq[0] = 1'b0; dReq[0] = 1'b0;
    wait_idle(0);

    // Store with dBe=0, and a fetch raised during WAIT.
    c = cyc;
    e.is_d = 1'b1; e.addr = 32'h0000_0050; e.we = 4'h0; e.wdata = 32'h55AA_55AA;
    e.rdata = 32'hC0DE_0044; e.cyc = c + 1; gq[0].push_back(e);
    e.cyc = c + 3; rq[0].push_back(e);
    e.is_d = 1'b0; e.addr = 32'h0000_0060; e.rdata = 32'hC0DE_0060;
    e.cyc = c + 4; gq[0].push_back(e);
    e.cyc = c + 6; rq[0].push_back(e);
    dReq[0] = 1'b1; dWe[0] = 1'b1; dAddr[0] = 32'h0000_0050; dBe[0] = 4'h0; dWdata[0] = 32'h55AA_55AA;
    @(negedge clk);
    chk(0, "t6_dgnt", {31'd0, dGnt[0]}, 32'd1);
    dReq[0] = 1'b0;
    @(negedge clk);
    iReq[0] = 1'b1; iAddr[0] = 32'h0000_0060;
    @(negedge clk);
    chk(0, "t6_no_gnt_in_resp", {31'd0, iGnt[0]}, 32'd0);
    @(negedge clk);
    chk(0, "t6_igrant_after_resp", {31'd0, iGnt[0]}, 32'd1);
    iReq[0] = 1'b0;
    wait_idle(0);

    // Reset during WAIT of a fetch: abandoned, then a fresh fetch.
    c = cyc;
    e.is_d = 1'b0; e.addr = 32'h0000_0070; e.we = 4'h0; e.wdata = 32'h0;
    e.rdata = 32'h0; e.cyc = c + 1; gq[0].push_back(e);
    iReq[0] = 1'b1; iAddr[0] = 32'h0000_0070;
    @(negedge clk);
    chk(0, "t5_igrant", {31'd0, iGnt[0]}, 32'd1);
    iReq[0] = 1'b0;
    @(negedge clk);
    chk(0, "t5_busy_wait", {31'd0, busy[0]}, 32'd1);
    rst[0] = 1'b1;
    @(negedge clk);
    chk(0, "t5_busy", {31'd0, busy[0]}, 32'd0);
    chk(0, "t5_ivalid", {31'd0, iValid[0]}, 32'd0);
    chk(0, "t5_memen", {31'd0, memEn[0]}, 32'd0);
    chk(0, "t5_memwe", {28'd0, memWe[0]}, 32'd0);
    chk(0, "t5_irdata", iRdata[0], 32'h0);
    chk(0, "t5_drdata", dRdata[0], 32'h0);
    chk(0, "t5_memaddr", memAddr[0], 32'h0);
    chk(0, "t5_memwdata", memWdata[0], 32'h0);
    rst[0] = 1'b0;
    @(negedge clk);
    issue(0, 1'b0, 1'b0, 32'h0000_0074, 4'h0, 32'h0, 32'h0000_0074, 32'hC0DE_0074);
    wait_idle(0);

    // MEM_LAT=3 load: valid at t+4, busy across t..t+4.
    issue(1, 1'b1, 1'b0, 32'h0000_0020, 4'h0, 32'h0, 32'h0000_0020, 32'h1234_5678);
    chk(1, "t4_busy_t", {31'd0, busy[1]}, 32'd1);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      chk(1, "t4_busy_window", {31'd0, busy[1]}, 32'd1);
    end
    @(negedge clk);
    chk(1, "t4_busy_end", {31'd0, busy[1]}, 32'd0);
    issue(1, 1'b0, 1'b0, 32'h0000_0023, 4'h0, 32'h0, 32'h0000_0020, 32'h1234_5678);
    wait_idle(1);

    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk(k, "gnt_queue_drained", 32'(gq[k].size()), 32'd0);
      chk(k, "resp_queue_drained", 32'(rq[k].size()), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
